// File: rtl/operand_fetch.sv
// operand_fetch: register file, pending-write scoreboard and a single-entry
// operand bundle register sitting between instruction issue and the ALU.
// An instruction is accepted only when its sources are not awaiting writeback.
// The accepted instruction's operands are registered and presented one cycle later.
// Optional feature macro: OPERAND_FETCH_BYPASS_EN. When it is defined,
// a same-cycle writeback is forwarded to a matching source operand.
module operand_fetch #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [3:0]        out_op,
  output logic [2:0]        out_rd,
  input  logic              wb_en,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [7:0]        busy
);

  // instruction fields; the low three bits carry nothing
  logic [3:0] op;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [2:0] rt;
  logic       instr_unused;

  assign op           = in_instr[15:12];
  assign rd           = in_instr[11:9];
  assign rs           = in_instr[8:6];
  assign rt           = in_instr[5:3];
  assign instr_unused = ^in_instr[2:0];

  logic [DATA_W-1:0] regs_reg [8];
  logic [7:0]        busy_reg;
  logic [7:0]        busy_next;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_a_reg;
  logic [DATA_W-1:0] out_b_reg;
  logic [3:0]        out_op_reg;
  logic [2:0]        out_rd_reg;

  logic              byp_s;
  logic              byp_t;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

`ifdef OPERAND_FETCH_BYPASS_EN
  // a writeback landing this cycle satisfies a matching source directly
  assign byp_s = wb_en && (wb_rd != 3'd0) && (wb_rd == rs);
  assign byp_t = wb_en && (wb_rd != 3'd0) && (wb_rd == rt);
`else
  // no forwarding: a source still marked busy waits for the register file
  assign byp_s = 1'b0;
  assign byp_t = 1'b0;
`endif

  assign hazard   = (busy_reg[rs] && !byp_s) || (busy_reg[rt] && !byp_t);
  assign in_ready = reset_n && (!out_valid_reg || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // operand selection: r0 reads zero, forwarded writeback, else register file
  always_comb begin
    opnd_a = regs_reg[rs];
    opnd_b = regs_reg[rt];
    if (byp_s) opnd_a = wb_data;
    if (byp_t) opnd_b = wb_data;
    if (rs == 3'd0) opnd_a = '0;
    if (rt == 3'd0) opnd_b = '0;
  end

  // scoreboard update: writeback clears first so a same-edge accept wins
  always_comb begin
    busy_next = busy_reg;
    if (wb_en) busy_next[wb_rd] = 1'b0;
    if (accept && (rd != 3'd0)) busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // register file writes; r0 is never written so it stays zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs_reg[i] <= '0;
    end else if (wb_en && (wb_rd != 3'd0)) begin
      regs_reg[wb_rd] <= wb_data;
    end
  end

  // scoreboard register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_reg <= '0;
    else          busy_reg <= busy_next;
  end

  // bundle register: load on accept, drop on consume, otherwise hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_op_reg    <= '0;
      out_rd_reg    <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_a_reg     <= opnd_a;
      out_b_reg     <= opnd_b;
      out_op_reg    <= op;
      out_rd_reg    <= rd;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_a     = out_a_reg;
  assign out_b     = out_b_reg;
  assign out_op    = out_op_reg;
  assign out_rd    = out_rd_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written multi-cycle
// sequences (hazard release, back-pressure, mid-run reset) and a randomized
// phase checked against an array-based reference model.
module tb_operand_fetch;

  localparam int DATA_W = 16;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clock;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [3:0]        out_op;
  logic [2:0]        out_rd;
  logic              wb_en;
  logic [2:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [7:0]        busy;

  operand_fetch #(.DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  logic [DATA_W-1:0] m_reg [8];
  logic [7:0]        m_busy;
  logic              m_valid;
  logic [DATA_W-1:0] m_a, m_b;
  logic [3:0]        m_op;
  logic [2:0]        m_rd;

  typedef struct {
    logic        iv;
    logic [15:0] ins;
    logic        we;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        rdy;
    logic        vld;
    logic [15:0] a, b;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [7:0]  bsy;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [15:0] mk_instr(input int op, input int rd, input int rs, input int rt);
    logic [15:0] w;
    w = '0;
    w[15:12] = op[3:0];
    w[11:9]  = rd[2:0];
    w[8:6]   = rs[2:0];
    w[5:3]   = rt[2:0];
    w[2:0]   = 3'b101;
    return w;
  endfunction

  function automatic vec_t mk_vec(input logic iv, input logic [15:0] ins, input logic we,
                                  input int wr, input int wd, input logic rdy, input logic vld,
                                  input int a, input int b, input int op, input int rd, input int bsy);
    vec_t v;
    v.iv = iv; v.ins = ins; v.we = we; v.wr = wr[2:0]; v.wd = wd[15:0];
    v.rdy = rdy; v.vld = vld; v.a = a[15:0]; v.b = b[15:0];
    v.op = op[3:0]; v.rd = rd[2:0]; v.bsy = bsy[7:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] ins, input logic ordy,
                       input logic we, input logic [2:0] wr, input logic [DATA_W-1:0] wd);
    in_valid  = iv;
    in_instr  = ins;
    out_ready = ordy;
    wb_en     = we;
    wb_rd     = wr;
    wb_data   = wd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_busy = '0; m_valid = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
  endtask

  // a source is blocked if pending, unless the same-cycle writeback forwards it
  function automatic logic model_src_blocked(input logic [2:0] r);
    return m_busy[r] && !(BYPASS && wb_en && wb_rd == r && r != 3'd0);
  endfunction

  function automatic logic model_in_ready();
    return reset_n && (!m_valid || out_ready) &&
           !(model_src_blocked(in_instr[8:6]) || model_src_blocked(in_instr[5:3]));
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [2:0] r);
    if (r == 3'd0) return '0;
    if (BYPASS && wb_en && wb_rd == r) return wb_data;
    return m_reg[r];
  endfunction

  // advance one clock edge and move the model to its post-edge state
  task automatic tick();
    logic              acc;
    logic [DATA_W-1:0] na, nb;
    acc = in_valid && model_in_ready();
    na  = model_read(in_instr[8:6]);
    nb  = model_read(in_instr[5:3]);
    @(posedge clock);
    #1;
    if (wb_en && wb_rd != 3'd0) m_reg[wb_rd] = wb_data;
    if (wb_en) m_busy[wb_rd] = 1'b0;
    if (acc && in_instr[11:9] != 3'd0) m_busy[in_instr[11:9]] = 1'b1;
    if (acc) begin
      m_valid = 1'b1; m_a = na; m_b = nb;
      m_op = in_instr[15:12]; m_rd = in_instr[11:9];
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    // directed table starting from a clean reset; out_ready=1 throughout
    vecs[0]  = mk_vec(1, mk_instr(0,1,0,0), 0,0,0,      1,1, 0,0,0,1,       8'h02);
    vecs[1]  = mk_vec(0, 16'h0000,          1,2,16'h5,  1,0, 0,0,0,0,       8'h02);
    vecs[2]  = mk_vec(1, mk_instr(1,4,2,0), 0,0,0,      1,1, 5,0,1,4,       8'h12);
    vecs[3]  = mk_vec(0, 16'h0000,          1,0,16'h1234,1,0, 0,0,0,0,      8'h12);
    vecs[4]  = mk_vec(1, mk_instr(2,5,0,2), 0,0,0,      1,1, 0,5,2,5,       8'h32);
    vecs[5]  = mk_vec(0, 16'h0000,          1,1,16'hA0, 1,0, 0,0,0,0,       8'h30);
    vecs[6]  = mk_vec(1, mk_instr(3,7,1,2), 0,0,0,      1,1, 16'hA0,5,3,7,  8'hB0);
    vecs[7]  = mk_vec(1, mk_instr(0,2,2,1), 0,0,0,      1,1, 5,16'hA0,0,2,  8'hB4);
    vecs[8]  = mk_vec(1, mk_instr(1,3,4,0), 0,0,0,      0,0, 0,0,0,0,       8'hB4);
    vecs[9]  = mk_vec(0, 16'h0000,          1,4,16'h11, 1,0, 0,0,0,0,       8'hA4);
    vecs[10] = mk_vec(1, mk_instr(0,3,4,0), 0,0,0,      1,1, 16'h11,0,0,3,  8'hAC);

    // reset: everything cleared and in_ready held low even with an offer
    reset_n = 1'b0;
    drive(1, 16'h0000, 1, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_a", out_a, 0);
    chk("reset_out_b", out_b, 0);
    chk("reset_out_op_rd", {out_op, out_rd}, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ins, 1, vecs[i].we, vecs[i].wr, vecs[i].wd);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].vld);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      if (vecs[i].vld) begin
        chk($sformatf("vec%0d_out_a", i), out_a, vecs[i].a);
        chk($sformatf("vec%0d_out_b", i), out_b, vecs[i].b);
        chk($sformatf("vec%0d_out_op", i), out_op, vecs[i].op);
        chk($sformatf("vec%0d_out_rd", i), out_rd, vecs[i].rd);
      end
    end

    // hazard on r3 released by a writeback of 16'h00FF
    drive(1, mk_instr(1,1,3,0), 1, 0, 0, 0);
    #1;
    chk("haz_blocked", in_ready, 0);
    tick();
    chk("haz_drained", out_valid, 0);
    drive(1, mk_instr(1,1,3,0), 1, 1, 3, 16'h00FF);
    #1;
    if (BYPASS) begin
      chk("haz_bypass_ready", in_ready, 1);
      tick();
    end else begin
      chk("haz_nobypass_wait", in_ready, 0);
      tick();
      chk("haz_nobypass_gap", out_valid, 0);
      drive(1, mk_instr(1,1,3,0), 1, 0, 0, 0);
      #1;
      chk("haz_nobypass_ready", in_ready, 1);
      tick();
    end
    chk("haz_out_valid", out_valid, 1);
    chk("haz_out_a", out_a, 16'h00FF);
    chk("haz_out_op", out_op, 1);
    chk("haz_busy", busy, 8'hA6);

    // back-pressure: bundle held three cycles, then swapped with no bubble
    for (int c = 0; c < 3; c++) begin
      drive(1, mk_instr(2,6,0,0), 0, 0, 0, 0);
      #1;
      chk($sformatf("hold%0d_in_ready", c), in_ready, 0);
      tick();
      chk($sformatf("hold%0d_bundle", c), {out_valid, out_a, out_b, out_op, out_rd},
          {1'b1, 16'h00FF, 16'h0000, 4'd1, 3'd1});
    end
    drive(1, mk_instr(2,6,0,0), 1, 0, 0, 0);
    #1;
    chk("swap_in_ready", in_ready, 1);
    tick();
    chk("swap_bundle", {out_valid, out_a, out_b, out_op, out_rd},
        {1'b1, 16'h0000, 16'h0000, 4'd2, 3'd6});
    chk("swap_busy", busy, 8'hE6);

    // reset pulled low mid-cycle with a live bundle and pending writes
    drive(0, 16'h0000, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(1, mk_instr(0,1,2,3), 1, 0, 0, 0);
    #1;
    chk("postrst_in_ready", in_ready, 1);
    tick();
    chk("postrst_bundle", {out_valid, out_a, out_b, out_rd}, {1'b1, 16'h0, 16'h0, 3'd1});
    chk("postrst_busy", busy, 8'h02);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom));
      #1;
      chk($sformatf("rnd%0d_in_ready", n), in_ready, model_in_ready());
      tick();
      chk($sformatf("rnd%0d_out_valid", n), out_valid, m_valid);
      chk($sformatf("rnd%0d_busy", n), busy, m_busy);
      if (m_valid)
        chk($sformatf("rnd%0d_bundle", n), {out_a, out_b, out_op, out_rd}, {m_a, m_b, m_op, m_rd});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width of registers and operands.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  instruction offered.
REQ-005 SHALL have port in_ready  output  1  instruction accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port in_instr  input  16  fields: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] ignored.
REQ-007 SHALL have port out_valid  output  1  operand bundle valid for the ALU.
REQ-008 SHALL have port out_ready  input  1  ALU consumes the bundle when out_valid && out_ready at a clock edge.
REQ-009 SHALL have port out_a  output  DATA_W  operand A, value of rs; drives ALU input_a.
REQ-010 SHALL have port out_b  output  DATA_W  operand B, value of rt; drives ALU input_b.
REQ-011 SHALL have port out_op  output  4  op field passed unchanged; drives ALU op (0 add, 1 sub, 2 and, 3 or; others unchanged).
REQ-012 SHALL have port out_rd  output  3  destination register, returned later on wb_rd.
REQ-013 SHALL have port wb_en  input  1  writeback strobe carrying the ALU result.
REQ-014 SHALL have port wb_rd  input  3  writeback destination.
REQ-015 SHALL have port wb_data  input  DATA_W  writeback value.
REQ-016 SHALL have port busy  output  8  per-register pending-write scoreboard.

Function
REQ-017 SHALL hold 8 registers r0..r7; r0 SHALL always read 0, and writes to r0 SHALL be ignored.
REQ-018 SHALL write wb_data into r[wb_rd] at the edge where wb_en=1.
REQ-019 SHALL register one bundle with 1-cycle latency: an instruction accepted at edge N appears on out_* with out_valid=1 after edge N.
REQ-020 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, combinationally.
REQ-021 SHALL define hazard = busy[rs] || busy[rt] for the offered instruction, except as relaxed by REQ-032.
REQ-022 SHALL keep out_a, out_b, out_op, out_rd, out_valid stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid on a consume edge when no new instruction is accepted at that edge.
REQ-024 SHALL load a new bundle at the same edge a held bundle is consumed (back-to-back, no bubble).
REQ-025 SHALL set busy[rd] when an instruction is accepted, unless rd=0; busy[0] SHALL stay 0.
REQ-026 SHALL clear busy[wb_rd] when wb_en=1.
REQ-027 SHALL let the set win when an accept sets busy[x] and a writeback clears busy[x] at the same edge.
REQ-028 SHALL let an instruction with rd equal to rs or rt and no busy sources issue, reading the old value.

Reset
REQ-029 SHALL, while reset_n=0, asynchronously force all registers to 0, busy=0, out_valid=0, and out_a/out_b/out_op/out_rd=0.
REQ-030 SHALL discard any in-flight bundle and pending writeback on reset assertion mid-operation; the first accept SHALL be possible at the first edge after reset_n rises.
REQ-031 SHALL keep in_ready=0 while reset_n=0.

Configuration
REQ-032 SHALL, with OPERAND_FETCH_BYPASS_EN defined: when wb_en=1 and wb_rd (nonzero) matches rs/rt, treat that source as not busy and capture wb_data as the operand in the same cycle.
REQ-033 SHALL, without OPERAND_FETCH_BYPASS_EN: a source matching a same-cycle writeback remains a hazard; the instruction SHALL issue one cycle later and read the register file value.

Verification
REQ-034 SHALL cover: reset, then in_instr={op=0,rd=1,rs=0,rt=0} accepted -> next cycle out_valid=1, out_a=0, out_b=0, out_op=0, out_rd=1, busy=8'b0000_0010.
REQ-035 SHALL cover: with wb_en=1, wb_rd=2, wb_data=16'h0005 applied, then op=1,rs=2,rt=0 -> out_a=5, out_b=0, out_op=1.
REQ-036 SHALL cover: busy[3]=1, offer rs=3 -> in_ready=0; wb_rd=3, wb_data=16'h00FF -> with bypass, accepted in the same cycle and out_a=16'h00FF; without bypass, accepted one cycle later and out_a=16'h00FF.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with a bundle held -> out_* unchanged and in_ready=0; out_ready=1 with a queued instruction -> new bundle on the next cycle with no bubble.
REQ-038 SHALL cover: wb_en=1, wb_rd=0, wb_data=16'h1234, then read rs=0 -> out_a=0.
REQ-039 SHALL cover: reset_n pulled low mid-clock with out_valid=1 and busy!=0 -> immediately out_valid=0, busy=0, and registers read 0 after release.
